muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit for the RV32M extension, sitting in the EX stage beside the single-cycle ALU. It accepts one operation per start pulse and computes it over multiple cycles: a radix-2 shift-add multiply or a restoring divide. It returns the result with a one-cycle `done` pulse; the pipeline stalls on `busy`. Divide-by-zero and signed overflow bypass iteration and complete in one cycle.

## Interface
- `XLEN`, default 32: operand/result width; even, ≥ 8.
- `CNT_W`, default $clog2(XLEN): iteration counter width (derived).
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: request; sampled only in IDLE.
- `flush`, input, 1: abort current operation (pipeline flush).
- `op`, input, 3: RV32M funct3 — 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1`, input, XLEN: operand A (multiplicand / dividend).
- `rs2`, input, XLEN: operand B (multiplier / divisor).
- `busy`, output, 1: high in CALC and FIX.
- `done`, output, 1: one-cycle pulse; `result` is valid in that cycle.
- `result`, output, XLEN: registered; held until the next accepted start.

## Operation
- States: IDLE, CALC, FIX, DONE.
  - IDLE & start & special case → DONE.
  - IDLE & start → CALC.
  - CALC with counter == 0 → FIX.
  - FIX → DONE.
  - DONE → IDLE.
- start is ignored outside IDLE. flush in any state → IDLE next cycle, no done pulse, result unchanged. flush has priority over start.
- On accept:
  - latch op and magnitudes. Signed operands are rs1 for MULH/MULHSU/DIV/REM and rs2 for MULH/DIV/REM.
  - latch negate flags: product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA.
  - load counter = XLEN-1.
- CALC multiply: 2·XLEN accumulator. Each cycle, add |A| to the upper half if the multiplier LSB is 1, then shift right 1.
- CALC divide: restoring. Shift {rem,quot} left 1, trial-subtract |B|, keep if non-negative, set quot LSB.
- FIX: conditional two's-complement negate of the product, quotient or remainder. Select the low half (MUL), high half (MULH*), quotient or remainder into `result`.
- Special cases (divide only, detected in IDLE):
  - B == 0: quotient = all-ones, remainder = rs1.
  - Signed DIV/REM with rs1 = 1<<(XLEN-1) and rs2 = all-ones: quotient = rs1, remainder = 0.
- All arithmetic is modulo 2^XLEN except the 2·XLEN product; MUL's low half is sign-independent.

## Timing
- Reset values: state IDLE, busy 0, done 0, result 0, counter 0.
- Reset asserted mid-operation aborts immediately; no done pulse follows.
- start sampled high at edge T. In this section, "cycle" means the clock cycle in which a signal is high.
- Normal path:
  - busy high in cycles T+1 … T+XLEN+1.
  - done high in cycle T+XLEN+2 (34 for XLEN=32).
  - busy low in the done cycle.
- Special path: done in cycle T+1, busy never asserted.
- Earliest next start: sampled in the cycle after done.
- done never asserts two cycles in a row.

## Structure
- Shared package `muldiv_pkg`:
  - op encodings as localparams (OP_MUL … OP_REMU);
  - state enum encoding;
  - helper function `is_div(op)`.
- One natural sub-module, `muldiv_sign_fix`: combinational conditional negate plus half/quotient/remainder select used in FIX. Everything else stays in `muldiv_unit`.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD → result 0xFFFFFFEB; done exactly 34 cycles after start; busy high for 33 cycles.
- rs1=rs2=0xFFFFFFFF:
  - MULHU → 0xFFFFFFFE;
  - MULH → 0x00000000;
  - MULHSU → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- Special cases, each done at T+1 with busy low:
  - DIVU 5/0 → 0xFFFFFFFF;
  - REM 5/0 → 5;
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000;
  - REM of the same operands → 0.
- flush asserted in cycle T+10 of a DIV:
  - busy low next cycle;
  - no done pulse;
  - result unchanged;
  - a new MUL started immediately completes correctly.
- rst_n pulsed low mid-CALC → all outputs 0 asynchronously; start while busy ignored; back-to-back ops complete in order.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op encodings, FSM state encoding and op-class helper.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Final sign correction and result select for the multiply/divide unit.
// Combinational; no state, no handshake.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] acc_hi,
  input  logic [XLEN-1:0] acc_lo,
  input  logic            neg_q,
  input  logic            neg_r,
  output logic [XLEN-1:0] result
);

  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;

  // Multiply: {hi,lo} is the full product; divide: hi = remainder, lo = quotient.
  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? -prod : prod;
  assign quot_fix = neg_q ? -acc_lo : acc_lo;
  assign rem_fix  = neg_r ? -acc_hi : acc_hi;

  always_comb begin
    result = '0;
    if (is_div(op)) begin
      result = op[1] ? rem_fix : quot_fix;
    end else if (op == OP_MUL) begin
      result = prod_fix[XLEN-1:0];
    end else begin
      result = prod_fix[2*XLEN-1:XLEN];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply (radix-2 shift-add) / restoring divide, one op per start.
// Normal ops finish XLEN+2 cycles after start; div-by-zero and signed overflow in one.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_t            state, state_nxt;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   acc_hi, acc_lo, opnd;
  logic [CNT_W-1:0]  cnt;
  logic              neg_q, neg_r;

  logic              a_signed, b_signed, sa, sb;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     mul_sum, rem_sh, div_diff;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [XLEN-1:0]   fix_res;

  assign a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign sa       = a_signed & rs1[XLEN-1];
  assign sb       = b_signed & rs2[XLEN-1];
  assign mag_a    = sa ? -rs1 : rs1;
  assign mag_b    = sb ? -rs2 : rs2;

  assign div_zero = is_div(op) && (rs2 == '0);
  assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                    (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = op[1] ? rs1 : '1;
    end else if (!op[1]) begin
      special_res = rs1;
    end
  end

  // One iteration of either algorithm; the accumulator pair is shared.
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign rem_sh   = {acc_hi, acc_lo[XLEN-1]};
  assign div_diff = rem_sh - {1'b0, opnd};

  always_comb begin
    step_hi = '0;
    step_lo = '0;
    if (is_div(op_q)) begin
      if (!div_diff[XLEN]) begin
        step_hi = div_diff[XLEN-1:0];
        step_lo = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        step_hi = rem_sh[XLEN-1:0];
        step_lo = {acc_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
  end

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .op     (op_q),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .neg_q  (neg_q),
    .neg_r  (neg_r),
    .result (fix_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = special ? ST_DONE : ST_CALC;
      ST_CALC: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = ST_FIX;
      end
      ST_FIX: begin
        busy      = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  // Flush freezes the datapath so result keeps its last delivered value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_MUL;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else if (!flush) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q   <= op;
            acc_hi <= '0;
            acc_lo <= is_div(op) ? mag_a : mag_b;
            opnd   <= is_div(op) ? mag_b : mag_a;
            cnt    <= CNT_W'(XLEN-1);
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            if (special) result <= special_res;
          end
        end
        ST_CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        ST_FIX:  result <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, flush/reset/ignored-start
// scenarios and randomized ops compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            flush = 1'b0;
  logic [2:0]      op = 3'd0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic            busy, done;
  logic [XLEN-1:0] result;

  int passed = 0;
  int total  = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    longint      p;
    logic [63:0] u;
    logic [63:0] ua, ub;
    sa = a;
    sb = b;
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: begin u = ua * ub; return u[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'(ub); return p[63:32]; end
      3'd3: begin u = ua * ub; return u[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return sa / sb;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Starts at a negedge; returns at the negedge of the cycle after done.
  // inject > 0 raises a stray start in that cycle, which must be ignored.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int inject);
    int lat_exp, busy_cnt, done_at;
    lat_exp  = is_special(f, a, b) ? 1 : XLEN + 2;
    busy_cnt = 0;
    done_at  = 0;
    op = f; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    for (int k = 1; k <= 60 && done_at == 0; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_at = k;
        chk({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
        chk({tag, " result"}, result, exp);
      end
      if (k == inject) begin
        start = 1'b1; op = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, " latency"}, done_at, lat_exp);
    chk({tag, " busy_cycles"}, busy_cnt, lat_exp - 1);
    @(negedge clk);
    chk({tag, " done_single"}, {31'd0, done}, 32'd0);
    chk({tag, " result_held"}, result, exp);
  endtask

  initial begin
    logic [31:0] prev, a, b;
    logic [2:0]  f;

    repeat (2) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    run_op("divu", 3'd5, 32'd100, 32'd7, 32'd14, 0);
    run_op("remu", 3'd7, 32'd100, 32'd7, 32'd2, 0);
    run_op("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("rem_by0", 3'd6, 32'd5, 32'd0, 32'd5, 0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

    // Flush in cycle T+10 of a divide.
    prev = result;
    op = 3'd4; rs1 = 32'h1234_5679; rs2 = 32'd123; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    chk("flush busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush done", {31'd0, done}, 32'd0);
    chk("flush result", result, prev);
    run_op("mul_after_flush", 3'd0, 32'd12345, 32'd678, 32'd8369910, 0);

    // Asynchronous reset in the middle of CALC.
    op = 3'd3; rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy", {31'd0, busy}, 32'd0);
    chk("arst done", {31'd0, done}, 32'd0);
    chk("arst result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Stray start while busy must not disturb the running op.
    run_op("ignore_start", 3'd1, 32'h8765_4321, 32'h0FED_CBA9,
           ref_model(3'd1, 32'h8765_4321, 32'h0FED_CBA9), 5);

    // Back-to-back randomized ops, biased toward corner operands.
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        3: a = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op("rand", f, a, b, ref_model(f, a, b), (i % 3 == 0) ? 20 : 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
